// File: rtl/input_debouncer_pkg.sv
// rtl/input_debouncer_pkg.sv - shared types and constants for the input debouncer
//
// Purpose: channel FSM state encoding and the default settling length used by
//          input_debouncer and debounce_channel.
// Ports:   none (package).

package input_debouncer_pkg;

    // Channel FSM: STABLE while the synchronised input matches the committed
    // output, SETTLING while a different candidate value is being timed.
    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } deb_state_t;

    // 10 ms of stability at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one synchronise-and-debounce channel of WIDTH bits
//
// Purpose: two-flop synchroniser (s1 -> s2) followed by a stability-counter
//          FSM. The committed value only changes after the synchronised input
//          has held one value for DEBOUNCE_CYCLES consecutive clocks. The whole
//          WIDTH-bit vector shares one counter, so any bit change restarts
//          settling and the output always updates atomically.
// Ports:
//   clk    in   1      clock
//   rst_n  in   1      asynchronous active-low reset
//   raw    in   WIDTH  unsynchronised input pins
//   level  out  WIDTH  debounced, registered level
//   rise   out  1      registered one-cycle pulse on a 0->1 commit (WIDTH=1 only,
//                      held at 0 for wider channels)

module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic             rise
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Terminal count: the counter reaches this value and commits on the next
    // matching sample, so it never exceeds DEBOUNCE_CYCLES-1 and never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               IS_BIT   = (WIDTH == 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    deb_state_t       state;
    deb_state_t       state_next;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] cand_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [WIDTH-1:0] level_next;
    logic             rise_next;
    logic             commit;

    // Two-flop synchroniser; nothing downstream looks at s1 or raw.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // State register, including the datapath registers the FSM owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STABLE;
            cand  <= '0;
            cnt   <= '0;
            level <= '0;
            rise  <= 1'b0;
        end else begin
            state <= state_next;
            cand  <= cand_next;
            cnt   <= cnt_next;
            level <= level_next;
            rise  <= rise_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            STABLE: begin
                if (s2 != level) begin
                    state_next = SETTLING;
                    cand_next  = s2;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next   = '0;
                end
            end
            SETTLING: begin
                if (s2 == level) begin
                    // Bounced back to the committed value: abandon the candidate.
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (s2 != cand) begin
                    // A new value appeared mid-settle (vector channel): restart timing.
                    cand_next  = s2;
                    cnt_next   = CNT_ONE;
                end else if (cnt == CNT_LAST) begin
                    commit     = 1'b1;
                    state_next = STABLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic. The pulse is registered alongside level so both become
    // visible on the same edge; a 1->0 commit never pulses.
    always_comb begin
        level_next = commit ? cand : level;
        rise_next  = IS_BIT && commit && cand[0] && !level[0];
    end

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - pushbutton and slide-switch conditioner for the switch-reader slave
//
// Purpose: synchronises the raw board pins into HCLK, debounces them and
//          produces a single-cycle pulse per button press. Every output is a
//          flop, so there is no combinational path from the pins.
// Ports:
//   HCLK         in   1             system clock
//   HRESETn      in   1             asynchronous active-low reset
//   RawButtons   in   NUM_BUTTONS   raw pushbutton pins, active high
//   RawSwitches  in   NUM_SWITCHES  raw switch pins
//   Buttons      out  NUM_BUTTONS   debounced button levels
//   ButtonPulse  out  NUM_BUTTONS   one-cycle pulse when Buttons[i] rises
//   Switches     out  NUM_SWITCHES  debounced switch vector, updated atomically

module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int NUM_BUTTONS     = 2,
    parameter int NUM_SWITCHES    = 16,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [NUM_BUTTONS-1:0]  RawButtons,
    input  logic [NUM_SWITCHES-1:0] RawSwitches,
    output logic [NUM_BUTTONS-1:0]  Buttons,
    output logic [NUM_BUTTONS-1:0]  ButtonPulse,
    output logic [NUM_SWITCHES-1:0] Switches
);

    // Derived; every channel uses the same counter width.
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    // Switch changes never pulse; the channel ties this to 0.
    logic switch_rise_unused;

    // Each button is an independent 1-bit channel with its own counter.
    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
        debounce_channel #(
            .WIDTH           (1),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_button (
            .clk   (HCLK),
            .rst_n (HRESETn),
            .raw   (RawButtons[i]),
            .level (Buttons[i]),
            .rise  (ButtonPulse[i])
        );
    end

    // The switch vector is one channel so the slave never sees a torn value.
    debounce_channel #(
        .WIDTH           (NUM_SWITCHES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_switches (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .raw   (RawSwitches),
        .level (Switches),
        .rise  (switch_rise_unused)
    );

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - scoreboard bench for input_debouncer with DEBOUNCE_CYCLES=4

module tb_input_debouncer;

    localparam int NB = 2;
    localparam int NS = 16;
    localparam int DC = 4;

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic [NB-1:0] RawButtons;
    logic [NS-1:0] RawSwitches;
    logic [NB-1:0] Buttons;
    logic [NB-1:0] ButtonPulse;
    logic [NS-1:0] Switches;

    input_debouncer #(
        .NUM_BUTTONS     (NB),
        .NUM_SWITCHES    (NS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .RawButtons  (RawButtons),
        .RawSwitches (RawSwitches),
        .Buttons     (Buttons),
        .ButtonPulse (ButtonPulse),
        .Switches    (Switches)
    );

    always #5 HCLK = ~HCLK;

    // Number of rising edges seen so far; read on falling edges.
    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        int            at;
        string         name;
        logic [NB-1:0] b;
        logic [NB-1:0] p;
        logic [NS-1:0] s;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    logic [NB-1:0] prev_b = '0;
    logic [NB-1:0] prev_p = '0;
    logic [NS-1:0] prev_s = '0;

    task automatic expect_at(input int at, input string name,
                             input logic [NB-1:0] b, input logic [NB-1:0] p,
                             input logic [NS-1:0] s);
        exp_t e;
        e.at   = at;
        e.name = name;
        e.b    = b;
        e.p    = p;
        e.s    = s;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge HCLK);
            n++;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: %0d expectations pending, want 0", name, q.size());
            q.delete();
        end
    endtask

    // Monitor: an output change, or a scheduled checkpoint, consumes one expectation.
    always @(negedge HCLK) begin
        logic changed;
        exp_t e;
        changed = (Buttons !== prev_b) || (ButtonPulse !== prev_p) || (Switches !== prev_s);
        if (changed || (q.size() != 0 && q[0].at <= cyc)) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change at cyc %0d: got b=%b p=%b s=%h, want no change",
                         cyc, Buttons, ButtonPulse, Switches);
            end else begin
                e = q.pop_front();
                if (e.at != cyc || Buttons !== e.b || ButtonPulse !== e.p || Switches !== e.s) begin
                    miscompares++;
                    $display("FAIL %s: got cyc %0d b=%b p=%b s=%h, want cyc %0d b=%b p=%b s=%h",
                             e.name, cyc, Buttons, ButtonPulse, Switches, e.at, e.b, e.p, e.s);
                end
            end
        end
        prev_b = Buttons;
        prev_p = ButtonPulse;
        prev_s = Switches;
    end

    initial begin
        int c;
        HRESETn     = 1'b1;
        RawButtons  = '0;
        RawSwitches = '0;
        #1 HRESETn = 1'b0;

        // 1. Reset and quiet inputs.
        @(negedge HCLK);
        c = cyc;
        expect_at(c + 2, "reset_hold_zero", 2'b00, 2'b00, 16'h0000);
        idle(3);
        c = cyc;
        HRESETn = 1'b1;
        expect_at(c + 20, "quiet_after_reset", 2'b00, 2'b00, 16'h0000);
        drain("t1");

        // 2. Clean press of button 0.
        idle(2);
        c = cyc;
        RawButtons[0] = 1'b1;
        expect_at(c + 6, "press0_rise", 2'b01, 2'b01, 16'h0000);
        expect_at(c + 7, "press0_pulse_end", 2'b01, 2'b00, 16'h0000);
        drain("t2");

        // 3. Bouncing button 1, then release, then a 3-cycle glitch.
        idle(2);
        c = cyc;
        RawButtons[1] = 1'b1; idle(1);
        RawButtons[1] = 1'b0; idle(1);
        RawButtons[1] = 1'b1; idle(1);
        RawButtons[1] = 1'b0; idle(1);
        RawButtons[1] = 1'b1;
        expect_at(c + 10, "bounce1_rise", 2'b11, 2'b10, 16'h0000);
        expect_at(c + 11, "bounce1_pulse_end", 2'b11, 2'b00, 16'h0000);
        drain("t3a");
        idle(2);
        c = cyc;
        RawButtons[1] = 1'b0;
        expect_at(c + 6, "release1_no_pulse", 2'b01, 2'b00, 16'h0000);
        drain("t3b");
        idle(2);
        c = cyc;
        RawButtons[1] = 1'b1;
        expect_at(c + 12, "glitch3_rejected", 2'b01, 2'b00, 16'h0000);
        idle(3);
        RawButtons[1] = 1'b0;
        drain("t3c");

        // 4. Switch vector restarts settling on a late bit flip.
        idle(2);
        c = cyc;
        RawSwitches = 16'hA5A5;
        expect_at(c + 8, "switch_commit_a5a4", 2'b01, 2'b00, 16'hA5A4);
        expect_at(c + 9, "switch_no_pulse", 2'b01, 2'b00, 16'hA5A4);
        idle(2);
        RawSwitches = 16'hA5A4;
        drain("t4");

        // 5. Release, simultaneous press, release of button 0.
        idle(2);
        c = cyc;
        RawButtons = 2'b00;
        expect_at(c + 6, "release0", 2'b00, 2'b00, 16'hA5A4);
        drain("t5a");
        idle(2);
        c = cyc;
        RawButtons = 2'b11;
        expect_at(c + 6, "press_both", 2'b11, 2'b11, 16'hA5A4);
        expect_at(c + 7, "press_both_end", 2'b11, 2'b00, 16'hA5A4);
        drain("t5b");
        idle(2);
        c = cyc;
        RawButtons = 2'b10;
        expect_at(c + 6, "release0_again", 2'b10, 2'b00, 16'hA5A4);
        expect_at(c + 7, "release0_no_pulse", 2'b10, 2'b00, 16'hA5A4);
        drain("t5c");

        // 6. Reset while button 0 is settling with cnt=2, inputs held through it.
        idle(2);
        c = cyc;
        RawButtons = 2'b11;
        expect_at(c + 5, "reset_clears", 2'b00, 2'b00, 16'h0000);
        idle(4);
        #2 HRESETn = 1'b0;
        idle(2);
        HRESETn = 1'b1;
        expect_at(c + 12, "held_through_reset", 2'b11, 2'b11, 16'hA5A4);
        expect_at(c + 13, "held_pulse_end", 2'b11, 2'b00, 16'hA5A4);
        drain("t6");

        idle(10);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions the raw board pushbuttons and slide switches before they reach the AHB switch-reader slave.
- Provides two-flop synchronisation into HCLK, debouncing by a stability counter, and a single-cycle rising-edge pulse per button.
- Outputs feed the slave's Switches and Buttons inputs directly, so the slave only ever sees clean, glitch-free levels.

Parameters:
- NUM_BUTTONS, 2, number of independent button channels.
- NUM_SWITCHES, 16, width of the switch vector.
- DEBOUNCE_CYCLES, 500000, consecutive stable HCLK cycles needed before an output changes. This is 10 ms at 50 MHz. Legal range is 2 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the stability counter. It is derived and must not be overridden.

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  asynchronous active-low reset.
- RawButtons  input  NUM_BUTTONS  unsynchronised pushbutton pins, active high.
- RawSwitches  input  NUM_SWITCHES  unsynchronised switch pins.
- Buttons  output  NUM_BUTTONS  debounced button levels.
- ButtonPulse  output  NUM_BUTTONS  one-HCLK pulse when Buttons[i] rises.
- Switches  output  NUM_SWITCHES  debounced switch vector, updated atomically.

Behaviour:
- Reset (asynchronous, HRESETn low) clears all of the following, with no exceptions:
  - sync flops, counters and FSMs;
  - Buttons=0, ButtonPulse=0, Switches=0.
- Synchroniser:
  - Each raw bit passes through two flops, s1 then s2.
  - The debounce logic sees only s2.
- Channel structure:
  - Each button is its own channel, 1 bit wide.
  - The switch vector is one channel NUM_SWITCHES wide, with a single shared counter. Any bit change restarts settling for the whole vector.
- Channel FSM, two states (STABLE, SETTLING), with registers out, cand and cnt:
  - STABLE, s2 == out: stay, cnt=0.
  - STABLE, s2 != out: go to SETTLING, cand<=s2, cnt<=1.
  - SETTLING, s2 == out (bounced back): go to STABLE, cnt<=0. out is unchanged.
  - SETTLING, s2 != out and s2 != cand (value changed again, vector case): cand<=s2, cnt<=1, stay.
  - SETTLING, s2 == cand and cnt == DEBOUNCE_CYCLES-1: out<=cand, go to STABLE, cnt<=0.
  - SETTLING, s2 == cand otherwise: cnt<=cnt+1.
- Latency:
  - A raw level held constant and first sampled at edge k appears on the output at edge k+1+DEBOUNCE_CYCLES.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles, as seen at s2, never reaches the output.
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1.
  - Never wraps.
- ButtonPulse[i]:
  - Registered. Asserted in the same cycle Buttons[i] first reads 1 (set when the FSM commits out 0→1), deasserted the next cycle.
  - Never asserted on a 1→0 commit.
  - Switch changes generate no pulse.
- Simultaneous events:
  - Channels are fully independent.
  - Both buttons may pulse in the same cycle.
- Button held through reset:
  - After HRESETn deasserts, Buttons rises DEBOUNCE_CYCLES+2 edges later, and a pulse is emitted.
  - The downstream edge detector therefore sees a legitimate press.
- Reset asserted mid-settling:
  - Clears immediately.
  - No partial commit.
- Outputs are glitch-free flop outputs with no combinational path from the raw pins.

Decomposition:
- Shared package input_debouncer_pkg contains:
  - typedef enum logic {STABLE, SETTLING} deb_state_t;
  - the DEFAULT_DEBOUNCE_CYCLES constant.
- One sub-module, debounce_channel, parameterised by WIDTH and DEBOUNCE_CYCLES. It contains the synchroniser, the FSM, out, and a rise-pulse output that is used only when WIDTH=1.
- The top level instantiates NUM_BUTTONS channels with WIDTH=1 (generate loop) and one channel with WIDTH=NUM_SWITCHES.

Test Plan (DEBOUNCE_CYCLES=4 for all):
1. Reset and quiet inputs: RawButtons=0, RawSwitches=0 through and after reset → Buttons=0, Switches=0 and ButtonPulse=0 for 20 cycles; all outputs 0 during reset.
2. Clean press: RawButtons[0] 0→1 before edge k, held → Buttons[0]=1 after edge k+5, ButtonPulse[0]=1 for exactly that cycle and 0 from edge k+6, Buttons[1] unaffected.
3. Bounce rejection: RawButtons[1] toggles 1,0,1,0 each cycle then settles at 1 → Buttons[1] never shows an intermediate value; exactly one ButtonPulse[1], five edges after the final settle; 3-cycle-high glitch then 0 → no change, no pulse.
4. Switch vector: RawSwitches 0x0000→0xA5A5, then one bit flips 2 cycles later to 0xA5A4 and is held → Switches jumps 0x0000→0xA5A4 directly, never 0xA5A5, with no pulse output.
5. Release and simultaneous press: both buttons pressed in the same cycle → both pulses in the same cycle. Later release of button 0 → Buttons[0]=0 after 5 edges, no pulse.
6. Reset mid-operation: assert HRESETn low while button 0 is settling with cnt=2 → immediate Buttons=0, cnt cleared. Raw held high through release of reset → Buttons[0]=1 and one pulse 6 edges after deassertion.
